// File: rtl/clock_text_pkg.sv
// Shared encodings for the clock text generator: mode states, ASCII constants,
// screen positions of the time fields and the line-2 mode tags.
package clock_text_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_SETH = 2'd1,
    MODE_SETM = 2'd2,
    MODE_SETS = 2'd3
  } mode_t;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_DIGIT0 = 8'h30;

  localparam logic [4:0] IDX_HH_T   = 5'd6;
  localparam logic [4:0] IDX_HH_O   = 5'd7;
  localparam logic [4:0] IDX_COLON1 = 5'd8;
  localparam logic [4:0] IDX_MM_T   = 5'd9;
  localparam logic [4:0] IDX_MM_O   = 5'd10;
  localparam logic [4:0] IDX_COLON2 = 5'd11;
  localparam logic [4:0] IDX_SS_T   = 5'd12;
  localparam logic [4:0] IDX_SS_O   = 5'd13;

  localparam logic [31:0] TXT_TIME = "TIME";
  localparam logic [39:0] TXT_MODE = "MODE ";

  localparam logic [23:0] TAG_RUN = "RUN";
  localparam logic [23:0] TAG_HRS = "HRS";
  localparam logic [23:0] TAG_MIN = "MIN";
  localparam logic [23:0] TAG_SEC = "SEC";

  function automatic logic [23:0] mode_tag(input mode_t m);
    case (m)
      MODE_SETH: return TAG_HRS;
      MODE_SETM: return TAG_MIN;
      MODE_SETS: return TAG_SEC;
      default:   return TAG_RUN;
    endcase
  endfunction

  // A blanked digit shows as a space so the selected field can flash.
  function automatic logic [7:0] digit_char(input logic [3:0] d, input logic blank);
    return blank ? CH_SPACE : (CH_DIGIT0 | {4'h0, d});
  endfunction

endpackage

// File: rtl/clock_text_gen_bcd_field.sv
// Two-digit BCD counter wrapping at MAXV; wrap is a combinational carry-out
// so a chained field updates on the same edge as the one that rolled over.
module bcd_field #(
  parameter int MAXV = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       wrap
);

  localparam logic [3:0] MAX_TENS = 4'(MAXV / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAXV % 10);

  logic [3:0] tens_reg;
  logic [3:0] ones_reg;
  logic       at_max;

  assign at_max = (tens_reg == MAX_TENS) && (ones_reg == MAX_ONES);
  assign wrap   = inc && at_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      tens_reg <= 4'd0;
      ones_reg <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens_reg <= 4'd0;
        ones_reg <= 4'd0;
      end else if (ones_reg == 4'd9) begin
        tens_reg <= tens_reg + 4'd1;
        ones_reg <= 4'd0;
      end else begin
        ones_reg <= ones_reg + 4'd1;
      end
    end
  end

  assign tens = tens_reg;
  assign ones = ones_reg;

endmodule

// File: rtl/clock_text_gen.sv
// HH:MM:SS clock with button-driven set mode, serving a 32-character LCD
// screen image through a registered read port.
module clock_text_gen
  import clock_text_pkg::*;
#(
  parameter int CLK_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnmode,
  input  logic       btninc,
  input  logic [4:0] rdaddr,
  output logic [7:0] rddata,
  output logic       tick1hz,
  output logic       setmode
);

  localparam int PW   = $clog2(CLK_HZ);
  localparam int HALF = CLK_HZ / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(HALF - 1);

  mode_t         mode_reg, mode_next;
  logic [1:0]    mode_sync_reg, inc_sync_reg;
  logic          mode_prev_reg, inc_prev_reg;
  logic          pm, pi, pi_acc;
  logic [PW-1:0] presc_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          phase_reg;
  logic          tick_now;
  logic          tick1hz_reg, setmode_reg;
  logic [7:0]    rddata_reg, char_next;
  logic [23:0]   tag;
  logic [2:0]    fld_inc, fld_wrap, blank;
  logic [3:0]    fld_tens [3];
  logic [3:0]    fld_ones [3];
  logic          unused_hour_wrap;

  // Button synchronizers and rising-edge detectors.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_sync_reg <= 2'b00;
      inc_sync_reg  <= 2'b00;
      mode_prev_reg <= 1'b0;
      inc_prev_reg  <= 1'b0;
    end else begin
      mode_sync_reg <= {mode_sync_reg[0], btnmode};
      inc_sync_reg  <= {inc_sync_reg[0], btninc};
      mode_prev_reg <= mode_sync_reg[1];
      inc_prev_reg  <= inc_sync_reg[1];
    end
  end

  assign pm     = mode_sync_reg[1] & ~mode_prev_reg;
  assign pi     = inc_sync_reg[1] & ~inc_prev_reg;
  // Mode advance wins over an increment arriving in the same cycle.
  assign pi_acc = pi & ~pm & (mode_reg != MODE_RUN);

  always_ff @(posedge clk) begin
    if (reset) mode_reg <= MODE_RUN;
    else       mode_reg <= mode_next;
  end

  always_comb begin
    mode_next = mode_reg;
    if (pm) begin
      case (mode_reg)
        MODE_RUN:  mode_next = MODE_SETH;
        MODE_SETH: mode_next = MODE_SETM;
        MODE_SETM: mode_next = MODE_SETS;
        default:   mode_next = MODE_RUN;
      endcase
    end
  end

  assign tick_now = (mode_reg == MODE_RUN) && (presc_reg == PRESC_TC);

  always_ff @(posedge clk) begin
    if (reset || mode_reg != MODE_RUN || tick_now) presc_reg <= '0;
    else                                          presc_reg <= presc_reg + PW'(1);
  end

  // Blink restarts on entering a SET state and on every accepted increment.
  always_ff @(posedge clk) begin
    if (reset || mode_next == MODE_RUN || pm || pi_acc) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (blink_cnt_reg == BLINK_TC) begin
      blink_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick1hz_reg <= 1'b0;
      setmode_reg <= 1'b0;
    end else begin
      tick1hz_reg <= tick_now;
      setmode_reg <= (mode_next != MODE_RUN);
    end
  end

  // Field 0 = seconds, 1 = minutes, 2 = hours; carries only ripple in RUN.
  assign fld_inc[0] = tick_now | (pi_acc && mode_reg == MODE_SETS);
  assign fld_inc[1] = ((mode_reg == MODE_RUN) && fld_wrap[0]) | (pi_acc && mode_reg == MODE_SETM);
  assign fld_inc[2] = ((mode_reg == MODE_RUN) && fld_wrap[1]) | (pi_acc && mode_reg == MODE_SETH);
  assign unused_hour_wrap = fld_wrap[2];

  for (genvar gi = 0; gi < 3; gi++) begin : g_field
    bcd_field #(.MAXV(gi == 2 ? 23 : 59)) u_field (
      .clk   (clk),
      .reset (reset),
      .inc   (fld_inc[gi]),
      .tens  (fld_tens[gi]),
      .ones  (fld_ones[gi]),
      .wrap  (fld_wrap[gi])
    );
  end

  assign blank[0] = phase_reg && (mode_reg == MODE_SETS);
  assign blank[1] = phase_reg && (mode_reg == MODE_SETM);
  assign blank[2] = phase_reg && (mode_reg == MODE_SETH);
  assign tag      = mode_tag(mode_reg);

  always_comb begin
    char_next = CH_SPACE;
    case (rdaddr)
      5'd0:       char_next = TXT_TIME[31:24];
      5'd1:       char_next = TXT_TIME[23:16];
      5'd2:       char_next = TXT_TIME[15:8];
      5'd3:       char_next = TXT_TIME[7:0];
      IDX_HH_T:   char_next = digit_char(fld_tens[2], blank[2]);
      IDX_HH_O:   char_next = digit_char(fld_ones[2], blank[2]);
      IDX_COLON1: char_next = CH_COLON;
      IDX_MM_T:   char_next = digit_char(fld_tens[1], blank[1]);
      IDX_MM_O:   char_next = digit_char(fld_ones[1], blank[1]);
      IDX_COLON2: char_next = CH_COLON;
      IDX_SS_T:   char_next = digit_char(fld_tens[0], blank[0]);
      IDX_SS_O:   char_next = digit_char(fld_ones[0], blank[0]);
      5'd16:      char_next = TXT_MODE[39:32];
      5'd17:      char_next = TXT_MODE[31:24];
      5'd18:      char_next = TXT_MODE[23:16];
      5'd19:      char_next = TXT_MODE[15:8];
      5'd20:      char_next = TXT_MODE[7:0];
      5'd21:      char_next = tag[23:16];
      5'd22:      char_next = tag[15:8];
      5'd23:      char_next = tag[7:0];
      default:    char_next = CH_SPACE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) rddata_reg <= CH_SPACE;
    else       rddata_reg <= char_next;
  end

  assign rddata  = rddata_reg;
  assign tick1hz = tick1hz_reg;
  assign setmode = setmode_reg;

endmodule

// File: tb/tb_clock_text_gen.sv
// Directed bench for clock_text_gen at CLK_HZ = 10: screen reads, set mode,
// blink, button priority, rollover and reset during set.
module tb_clock_text_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnmode;
  logic       btninc;
  logic [4:0] rdaddr;
  logic [7:0] rddata;
  logic       tick1hz;
  logic       setmode;

  int total = 0;
  int bad   = 0;

  clock_text_gen #(.CLK_HZ(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .btnmode (btnmode),
    .btninc  (btninc),
    .rdaddr  (rdaddr),
    .rddata  (rddata),
    .tick1hz (tick1hz),
    .setmode (setmode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_char(input int a, output logic [7:0] c);
    rdaddr = 5'(a);
    step();
    c = rddata;
  endtask

  // Button held 2 cycles, released 2 cycles; the field has changed on return.
  task automatic press(input logic m, input logic i);
    btnmode = m;
    btninc  = i;
    step();
    step();
    btnmode = 1'b0;
    btninc  = 1'b0;
    step();
    step();
  endtask

  task automatic press_n(input logic m, input logic i, input int n);
    repeat (n) press(m, i);
  endtask

  task automatic test_reset();
    string exp = "TIME  00:00:00  MODE RUN        ";
    logic [7:0] c;
    reset = 1'b1; btnmode = 1'b0; btninc = 1'b0; rdaddr = 5'd0;
    step();
    step();
    total++;
    if (rddata !== 8'h20) begin bad++; $display("FAIL reset_rddata: got %h want 20", rddata); end
    total++;
    if (tick1hz !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick1hz); end
    total++;
    if (setmode !== 1'b0) begin bad++; $display("FAIL reset_setmode: got %b want 0", setmode); end
    // Re-reset before each chunk so seconds stay at 00 while reading.
    for (int chunk = 0; chunk < 4; chunk++) begin
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
        read_char(chunk * 8 + k, c);
        total++;
        if (c !== 8'(exp[chunk * 8 + k])) begin
          bad++;
          $display("FAIL screen[%0d]: got %h want %h", chunk * 8 + k, c, 8'(exp[chunk * 8 + k]));
        end
      end
    end
    $display("test_reset: screen read done, bad=%0d", bad);
  endtask

  task automatic test_set_hours_wrap();
    int addrs[9] = '{6, 7, 9, 10, 12, 13, 21, 22, 23};
    string exp = "010000HRS";
    logic [7:0] c;
    reset = 1'b1;
    step();
    reset = 1'b0;
    press(1'b1, 1'b0);
    total++;
    if (setmode !== 1'b1) begin bad++; $display("FAIL seth_setmode: got %b want 1", setmode); end
    press_n(1'b0, 1'b1, 25);
    for (int k = 0; k < 9; k++) begin
      read_char(addrs[k], c);
      total++;
      if (c !== 8'(exp[k])) begin
        bad++;
        $display("FAIL hrs_read[%0d]: got %h want %h", addrs[k], c, 8'(exp[k]));
      end
    end
    total++;
    if (tick1hz !== 1'b0) begin bad++; $display("FAIL seth_tick: got %b want 0", tick1hz); end
    $display("test_set_hours_wrap: 25 increments done, bad=%0d", bad);
  endtask

  task automatic test_simultaneous();
    int addrs[5] = '{21, 22, 23, 6, 7};
    string exp = "MIN01";
    logic [7:0] c;
    press(1'b1, 1'b1);
    total++;
    if (setmode !== 1'b1) begin bad++; $display("FAIL simul_setmode: got %b want 1", setmode); end
    for (int k = 0; k < 5; k++) begin
      read_char(addrs[k], c);
      total++;
      if (c !== 8'(exp[k])) begin
        bad++;
        $display("FAIL simul_read[%0d]: got %h want %h", addrs[k], c, 8'(exp[k]));
      end
    end
    $display("test_simultaneous: mode+inc together done, bad=%0d", bad);
  endtask

  task automatic test_blink();
    logic [7:0] c;
    // An accepted increment restarts the blink; 5 idle edges later MM blanks.
    press(1'b0, 1'b1);
    repeat (4) step();
    read_char(9, c);
    total++;
    if (c !== 8'h20) begin bad++; $display("FAIL blink_mm_t: got %h want 20", c); end
    read_char(10, c);
    total++;
    if (c !== 8'h20) begin bad++; $display("FAIL blink_mm_o: got %h want 20", c); end
    read_char(6, c);
    total++;
    if (c !== 8'h30) begin bad++; $display("FAIL blink_hh_t: got %h want 30", c); end
    press(1'b0, 1'b1);
    read_char(9, c);
    total++;
    if (c !== 8'h30) begin bad++; $display("FAIL unblink_mm_t: got %h want 30", c); end
    read_char(10, c);
    total++;
    if (c !== 8'h32) begin bad++; $display("FAIL unblink_mm_o: got %h want 32", c); end
    $display("test_blink: blank and restore done, bad=%0d", bad);
  endtask

  task automatic test_rollover();
    int addrs[9] = '{6, 7, 9, 10, 12, 13, 21, 22, 23};
    string exp = "000000RUN";
    logic [7:0] c;
    int ticks;
    press_n(1'b0, 1'b1, 57);          // MM 02 -> 59
    press(1'b1, 1'b0);                // SETS
    press_n(1'b0, 1'b1, 59);          // SS -> 59
    press(1'b1, 1'b0);                // RUN
    press(1'b1, 1'b0);                // SETH
    press_n(1'b0, 1'b1, 22);          // HH 01 -> 23
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);                // back to RUN at 23:59:59
    total++;
    if (setmode !== 1'b0) begin bad++; $display("FAIL roll_setmode: got %b want 0", setmode); end
    ticks = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (tick1hz === 1'b1) ticks++;
    end
    total++;
    if (ticks != 1 || tick1hz !== 1'b1) begin
      bad++;
      $display("FAIL roll_tick: got count=%0d last=%b want count=1 last=1", ticks, tick1hz);
    end
    for (int k = 0; k < 9; k++) begin
      read_char(addrs[k], c);
      total++;
      if (c !== 8'(exp[k])) begin
        bad++;
        $display("FAIL roll_read[%0d]: got %h want %h", addrs[k], c, 8'(exp[k]));
      end
    end
    $display("test_rollover: 23:59:59 wrap done, bad=%0d", bad);
  endtask

  task automatic test_reset_mid_set();
    int pre_addrs[6] = '{12, 13, 6, 7, 9, 10};
    string pre_exp = "561234";
    string post_exp = "00:00:00RUN";
    logic [7:0] c;
    reset = 1'b1;
    step();
    reset = 1'b0;
    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 12);
    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 34);
    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 56);
    for (int k = 0; k < 6; k++) begin
      read_char(pre_addrs[k], c);
      total++;
      if (c !== 8'(pre_exp[k])) begin
        bad++;
        $display("FAIL preset_read[%0d]: got %h want %h", pre_addrs[k], c, 8'(pre_exp[k]));
      end
    end
    total++;
    if (setmode !== 1'b1) begin bad++; $display("FAIL sets_setmode: got %b want 1", setmode); end
    reset = 1'b1;
    step();
    total++;
    if (setmode !== 1'b0) begin bad++; $display("FAIL midreset_setmode: got %b want 0", setmode); end
    total++;
    if (rddata !== 8'h20) begin bad++; $display("FAIL midreset_rddata: got %h want 20", rddata); end
    reset = 1'b0;
    for (int k = 0; k < 11; k++) begin
      read_char(k < 8 ? 6 + k : 13 + k, c);
      total++;
      if (c !== 8'(post_exp[k])) begin
        bad++;
        $display("FAIL midreset_read[%0d]: got %h want %h", k < 8 ? 6 + k : 13 + k, c, 8'(post_exp[k]));
      end
    end
    $display("test_reset_mid_set: reset from 12:34:56 done, bad=%0d", bad);
  endtask

  initial begin
    reset   = 1'b1;
    btnmode = 1'b0;
    btninc  = 1'b0;
    rdaddr  = 5'd0;
    test_reset();
    test_set_hours_wrap();
    test_simultaneous();
    test_blink();
    test_rollover();
    test_reset_mid_set();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
